// File: rtl/axis_rr_packet_arbiter_if.sv
// Bundle of N AXIS producer lanes plus the single shared AXIS consumer lane.
// Latency: none, this is wiring only.
// Backpressure: input_ready and output_ready travel in the same bundle as the data.
interface axis_rr_packet_arbiter_if #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 10,
    parameter int ID_WIDTH   = 2
);
    logic [NUM_INPUTS-1:0]            input_valid;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] input_data;
    logic [NUM_INPUTS-1:0]            input_last;
    logic [NUM_INPUTS-1:0]            input_ready;
    logic                             output_valid;
    logic [DATA_WIDTH-1:0]            output_data;
    logic                             output_last;
    logic [ID_WIDTH-1:0]              output_id;
    logic                             output_ready;

    // Arbiter side: consumes the producer lanes and drives the shared lane.
    modport slave (
        input  input_valid, input_data, input_last,
        output input_ready,
        output output_valid, output_data, output_last, output_id,
        input  output_ready
    );

    // Environment side: producers and the downstream sink.
    modport master (
        output input_valid, input_data, input_last,
        input  input_ready,
        input  output_valid, output_data, output_last, output_id,
        output output_ready
    );
endinterface

// File: rtl/axis_rr_packet_arbiter.sv
// Round-robin packet arbiter: merges NUM_INPUTS AXIS streams onto one, tagging beats with source id.
// Latency: 1 cycle to grant from IDLE, 1 cycle from accepted beat to output_valid.
// Backpressure: only the granted input sees ready = !output_valid || output_ready; others are held off.
module axis_rr_packet_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 10,
    parameter int ID_WIDTH   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    axis_rr_packet_arbiter_if.slave   bus
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]            state;
    logic [ID_WIDTH-1:0]   grant;
    logic [ID_WIDTH-1:0]   last_grant;
    logic [ID_WIDTH-1:0]   next_grant;
    logic [ID_WIDTH-1:0]   cand;
    logic                  any_req;

    logic [NUM_INPUTS-1:0] ready_vec;
    logic                  grant_rdy;
    logic                  accept;
    logic [DATA_WIDTH-1:0] grant_dat;
    logic                  grant_last;

    logic                  out_vld;
    logic [DATA_WIDTH-1:0] out_dat;
    logic                  out_last;
    logic [ID_WIDTH-1:0]   out_id;

    // Round-robin search starting just after the last granted input; the
    // descending scan lets the nearest requester overwrite farther ones.
    always_comb begin
        next_grant = '0;
        any_req    = 1'b0;
        cand       = '0;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
            cand = ID_WIDTH'((int'(last_grant) + k) % NUM_INPUTS);
            if (bus.input_valid[cand]) begin
                next_grant = cand;
                any_req    = 1'b1;
            end
        end
    end

    // The output stage can take a new beat when empty or draining this cycle.
    assign grant_rdy  = !out_vld || bus.output_ready;
    assign grant_dat  = bus.input_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    assign grant_last = bus.input_last[grant];
    assign accept     = (state == ST_LOCKED) && !rst && bus.input_valid[grant] && grant_rdy;

    // Only the locked input ever sees ready; reset forces all ready bits low.
    always_comb begin
        ready_vec = '0;
        if ((state == ST_LOCKED) && !rst) begin
            ready_vec[grant] = grant_rdy;
        end
    end

    // Grant FSM: arbitrate in IDLE, hold the grant until the last beat is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= ID_WIDTH'(NUM_INPUTS - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant <= next_grant;
                        state <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (accept && grant_last) begin
                        last_grant <= grant;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Output register: reload on accept, clear valid on a drain with no reload.
    // Data fields hold after a drain so the bus stays quiet between packets.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_last <= 1'b0;
            out_id   <= '0;
        end else if (accept) begin
            out_vld  <= 1'b1;
            out_dat  <= grant_dat;
            out_last <= grant_last;
            out_id   <= grant;
        end else if (out_vld && bus.output_ready) begin
            out_vld  <= 1'b0;
        end
    end

    assign bus.input_ready  = ready_vec;
    assign bus.output_valid = out_vld;
    assign bus.output_data  = out_dat;
    assign bus.output_last  = out_last;
    assign bus.output_id    = out_id;

endmodule

// File: doc/axis_rr_packet_arbiter.md
Name: axis_rr_packet_arbiter

Overview:
- Shares one AXIS output between NUM_INPUTS AXIS producers.
- Arbitration is round-robin at packet granularity. A grant, once given, is held until the granted input delivers a beat with last asserted.
- Data passes through a single registered output stage. The output carries the source index so downstream checkers and writers can demultiplex streams.
- Sits between parallel coder lanes and a single shared sink (bitstream writer or stream checker).

Parameters:
- NUM_INPUTS, 4, number of requesting AXIS inputs; legal range 2..16.
- DATA_WIDTH, 10, width of each beat.
- ID_WIDTH, 2, width of output_id; must equal ceil(log2(NUM_INPUTS)).

Ports:
- clk  in  1  clock; all logic samples on the rising edge.
- rst  in  1  synchronous, active-high reset.
- input_valid  in  NUM_INPUTS  per-input valid; bit i belongs to input i.
- input_data  in  NUM_INPUTS*DATA_WIDTH  per-input beat; slice [i*DATA_WIDTH +: DATA_WIDTH] belongs to input i.
- input_last  in  NUM_INPUTS  per-input end-of-packet flag.
- input_ready  out  NUM_INPUTS  per-input ready.
- output_valid  out  1  output beat valid.
- output_data  out  DATA_WIDTH  output beat.
- output_last  out  1  end-of-packet flag of the output beat.
- output_id  out  ID_WIDTH  index of the input that produced the output beat.
- output_ready  in  1  downstream ready.

Behaviour:
- Reset, applied on any clk edge with rst=1, regardless of the state or of a packet in flight:
  - state=IDLE, last_grant=NUM_INPUTS-1, so input 0 has top priority first.
  - output_valid=0, output_data=0, output_last=0, output_id=0.
  - input_ready=0 throughout reset.
  - A packet in flight is abandoned. No partial-packet recovery.
- State machine, two states:
  - IDLE:
    - All input_ready=0.
    - If any input_valid=1, select the first requester found by scanning last_grant+1, last_grant+2, … modulo NUM_INPUTS.
    - Register that index as grant and move to LOCKED at the next edge.
    - If no input_valid=1, stay in IDLE.
  - LOCKED(g):
    - input_ready[g] = !output_valid || output_ready. This is combinational from the output register state and output_ready.
    - All other input_ready bits are 0.
    - A beat is accepted when input_valid[g] && input_ready[g].
    - When the accepted beat has input_last[g]=1: set last_grant=g and go to IDLE at the same edge.
- Grant latency:
  - A request arriving in IDLE is granted one cycle later.
  - The first beat can be accepted in the cycle after the grant.
  - There is one dead cycle between packets: the arbitration cycle spent in IDLE.
- Output register:
  - On acceptance, output_data, output_last and output_id are loaded from the granted input and g, and output_valid=1 at the next edge.
  - If the output beat drains (output_valid && output_ready) with no acceptance in the same cycle, output_valid=0 at the next edge. The data fields hold their last value.
  - If a drain and an acceptance occur in the same cycle, the register reloads and output_valid stays 1. This sustains 1 beat/cycle within a packet.
  - Output latency is exactly 1 cycle from acceptance to output_valid.
- AXIS rules:
  - output_valid never deasserts without a handshake.
  - output fields are stable while output_valid && !output_ready.
  - Behaviour is not required to tolerate an input dropping input_valid mid-packet. The grant simply holds until its last beat.
- Single-beat packets (input_last=1 on the first beat) are legal: LOCKED lasts exactly one accepting cycle.
- Non-granted inputs asserting valid never affect the current packet. They are considered only at the next IDLE.
- Starvation bound: a continuously requesting input is granted within NUM_INPUTS-1 packets of other inputs.

Test Plan:
1. Reset, then input 2 only sends packet {0x011, 0x012, 0x013(last)} with output_ready=1.
   -> Grant in cycle 1. Beats appear on cycles 3, 4, 5 with output_id=2; output_last=1 on 0x013 only; state returns to IDLE.
2. All 4 inputs continuously send 2-beat packets, data = 0x100*i + beat.
   -> Output packet order is ids 0, 1, 2, 3, 0, …. Never two consecutive packets from the same id while others are requesting.
3. Input 1 mid-packet, output_ready held 0 for 3 cycles.
   -> output_valid stays 1 and output_data stays constant. input_ready[1]=0 during the stall; no beat is lost or duplicated once ready returns.
4. Input 0 sends a single-beat packet 0x3FF(last) while input 3 waits.
   -> Output 0x3FF with id=0 and last=1. Input 3 is granted next, with the single IDLE cycle between them.
5. rst asserted during beat 2 of a 4-beat packet from input 1.
   -> After the reset edge: output_valid=0, all input_ready=0, IDLE. The next arbitration favours input 0.
6. Scoreboard run: 4 random-length streams with random output_ready.
   -> Each id's beat sequence on the output matches its input sequence exactly; every packet is contiguous on the output.
